// File: rtl/data_mem_access_ctrl.sv
// Load/store initiator between the execute stage and a word/byte data RAM.
// Performs extension of load data, splits SH into two byte writes and flags bad accesses.
module data_mem_access_ctrl #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   ADDR_MAX      = 32'h0001_FFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     mem_we,
    output logic [1:0]               mem_dataType,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_BYTE = 2'b01;
    localparam logic [1:0] DT_HALF = 2'b10;

    state_t                   state, next_state;
    logic                     we_q, err_q;
    logic [2:0]               funct3_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q, rdata_q, load_ext;

    logic                     f3_ok, align_ok, req_err;
    logic [1:0]               size_m1;
    logic [ADDRESS_WIDTH:0]   last_byte;

    // Request check; the extra address bit keeps the last-byte sum from wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        f3_ok    = 1'b0;
        align_ok = 1'b1;
        size_m1  = 2'd0;
        case (req_funct3)
            F3_B:  f3_ok = 1'b1;
            F3_H:  begin f3_ok = 1'b1;    size_m1 = 2'd1; align_ok = ~req_addr[0]; end
            F3_W:  begin f3_ok = 1'b1;    size_m1 = 2'd3; align_ok = (req_addr[1:0] == 2'b00); end
            F3_BU: f3_ok = ~req_we;
            F3_HU: begin f3_ok = ~req_we; size_m1 = 2'd1; align_ok = ~req_addr[0]; end
            default: ;
        endcase
        last_byte = {1'b0, req_addr} + (ADDRESS_WIDTH+1)'(size_m1);
        req_err   = !f3_ok || !align_ok || (last_byte > {1'b0, ADDR_MAX});
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = req_err ? RESP : ACCESS;
            ACCESS:  next_state = (we_q && funct3_q == F3_H) ? SPLIT : RESP;
            SPLIT:   next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        case (funct3_q)
            F3_B:    load_ext = {{(DATA_WIDTH-8){mem_rd[7]}},   mem_rd[7:0]};
            F3_H:    load_ext = {{(DATA_WIDTH-16){mem_rd[15]}}, mem_rd[15:0]};
            F3_BU:   load_ext = {{(DATA_WIDTH-8){1'b0}},        mem_rd[7:0]};
            F3_HU:   load_ext = {{(DATA_WIDTH-16){1'b0}},       mem_rd[15:0]};
            default: load_ext = mem_rd;
        endcase
    end

    // RAM port decoded from registered state only, so reset silences it immediately.
    always_comb begin
        mem_we       = 1'b0;
        mem_dataType = DT_WORD;
        mem_addr     = '0;
        mem_wd       = '0;
        case (state)
            ACCESS: begin
                mem_addr = addr_q;
                if (we_q) begin
                    mem_we = 1'b1;
                    if (funct3_q == F3_W) begin
                        mem_wd = wdata_q;
                    end else begin
                        mem_dataType = DT_BYTE;
                        mem_wd       = {{(DATA_WIDTH-8){1'b0}}, wdata_q[7:0]};
                    end
                end else begin
                    case (funct3_q)
                        F3_B, F3_BU: mem_dataType = DT_BYTE;
                        F3_H, F3_HU: mem_dataType = DT_HALF;
                        default:     mem_dataType = DT_WORD;
                    endcase
                end
            end
            SPLIT: begin
                mem_we       = 1'b1;
                mem_dataType = DT_BYTE;
                mem_addr     = addr_q + 1'b1;
                mem_wd       = {{(DATA_WIDTH-8){1'b0}}, wdata_q[15:8]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= next_state;
            if (state == IDLE && req_valid) begin
                we_q     <= req_we;
                err_q    <= req_err;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rdata_q  <= '0;
            end
            if (state == ACCESS && !we_q) rdata_q <= load_ext;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Directed bench for data_mem_access_ctrl: byte-array RAM model, vector table
// for single requests, hand sequences for the SH split and reset during SPLIT.
module tb_data_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [1:0]  mem_dataType;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    logic [7:0]  ram [0:131071];
    int          wr_count   = 0;
    int          resp_count = 0;
    int          n_cmp      = 0;
    int          n_fail     = 0;

    data_mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_dataType(mem_dataType), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read (halfword zero-extended), synchronous word/byte write.
    always_comb begin
        case (mem_dataType)
            2'b00:   mem_rd = {ram[17'(mem_addr + 3)], ram[17'(mem_addr + 2)],
                               ram[17'(mem_addr + 1)], ram[17'(mem_addr)]};
            2'b01:   mem_rd = {24'h0, ram[17'(mem_addr)]};
            2'b10:   mem_rd = {16'h0, ram[17'(mem_addr + 1)], ram[17'(mem_addr)]};
            default: mem_rd = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            wr_count++;
            if (mem_dataType == 2'b00) begin
                ram[17'(mem_addr)]     = mem_wd[7:0];
                ram[17'(mem_addr + 1)] = mem_wd[15:8];
                ram[17'(mem_addr + 2)] = mem_wd[23:16];
                ram[17'(mem_addr + 3)] = mem_wd[31:24];
            end else if (mem_dataType == 2'b01) begin
                ram[17'(mem_addr)] = mem_wd[7:0];
            end
        end
        if (resp_valid) resp_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 10);
        check("wait_ready timeout", 32'(req_ready), 32'd1);
    endtask

    // Issue one request; return response data/error, cycles from accept edge, and RAM writes made.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output int writes);
        int wc0;
        wait_ready();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        wc0 = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata  = resp_rdata;
        err    = resp_err;
        writes = wr_count - wc0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, wr, rc0;

        for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
        ram[17'h01000] = 8'h78; ram[17'h01001] = 8'h56;
        ram[17'h01002] = 8'h34; ram[17'h01003] = 8'h12;
        ram[17'h01011] = 8'h80;
        ram[17'h01012] = 8'h01; ram[17'h01013] = 8'h80;
        ram[17'h01006] = 8'h77;
        ram[17'h01025] = 8'h55;

        //           we    f3      addr           wdata          rdata          err  lat wr
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_1000, 32'h0,         32'h1234_5678, 1'b0, 2, 0};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_1011, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 0};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_1011, 32'h0,         32'h0000_0080, 1'b0, 2, 0};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_1012, 32'h0,         32'hFFFF_8001, 1'b0, 2, 0};
        vecs[4]  = '{1'b0, 3'b101, 32'h0000_1012, 32'h0,         32'h0000_8001, 1'b0, 2, 0};
        vecs[5]  = '{1'b1, 3'b010, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_1008, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0};
        vecs[7]  = '{1'b1, 3'b000, 32'h0000_100B, 32'h0000_0011, 32'h0,         1'b0, 2, 1};
        vecs[8]  = '{1'b0, 3'b010, 32'h0000_1008, 32'h0,         32'h11AD_BEEF, 1'b0, 2, 0};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_1002, 32'h0,         32'h0,         1'b1, 1, 0};
        vecs[10] = '{1'b0, 3'b001, 32'h0000_1003, 32'h0,         32'h0,         1'b1, 1, 0};
        vecs[11] = '{1'b1, 3'b010, 32'h0001_FFFE, 32'h1234_5678, 32'h0,         1'b1, 1, 0};
        vecs[12] = '{1'b1, 3'b010, 32'h0001_FFFC, 32'hCAFE_F00D, 32'h0,         1'b0, 2, 1};
        vecs[13] = '{1'b0, 3'b010, 32'h0001_FFFC, 32'h0,         32'hCAFE_F00D, 1'b0, 2, 0};
        vecs[14] = '{1'b0, 3'b000, 32'h0001_FFFF, 32'h0,         32'hFFFF_FFCA, 1'b0, 2, 0};
        vecs[15] = '{1'b0, 3'b000, 32'h0002_0000, 32'h0,         32'h0,         1'b1, 1, 0};
        vecs[16] = '{1'b0, 3'b011, 32'h0000_1000, 32'h0,         32'h0,         1'b1, 1, 0};
        vecs[17] = '{1'b1, 3'b100, 32'h0000_1000, 32'h0000_00FF, 32'h0,         1'b1, 1, 0};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        check("reset req_ready",  32'(req_ready),    32'd1);
        check("reset resp_valid", 32'(resp_valid),   32'd0);
        check("reset resp_err",   32'(resp_err),     32'd0);
        check("reset resp_rdata", resp_rdata,        32'h0);
        check("reset mem_we",     32'(mem_we),       32'd0);
        check("reset mem_type",   32'(mem_dataType), 32'd0);
        check("reset mem_addr",   mem_addr,          32'h0);
        check("reset mem_wd",     mem_wd,            32'h0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, wr);
            check($sformatf("vec%0d rdata", i),   rd,       vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i),     32'(er),  32'(vecs[i].exp_err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d writes", i),  32'(wr),  32'(vecs[i].exp_wr));
        end

        // SH 0x1004: two byte writes on consecutive cycles, response at N+3.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h0000_1004; req_wdata = 32'hAABB_CCDD;
        @(posedge clk); #1; req_valid = 1'b0;
        check("sh access we",    32'(mem_we),       32'd1);
        check("sh access type",  32'(mem_dataType), 32'd1);
        check("sh access addr",  mem_addr,          32'h0000_1004);
        check("sh access wd",    32'(mem_wd[7:0]),  32'h0000_00DD);
        check("sh access ready", 32'(req_ready),    32'd0);
        @(posedge clk); #1;
        check("sh split we",     32'(mem_we),       32'd1);
        check("sh split type",   32'(mem_dataType), 32'd1);
        check("sh split addr",   mem_addr,          32'h0000_1005);
        check("sh split wd",     32'(mem_wd[7:0]),  32'h0000_00CC);
        check("sh split resp",   32'(resp_valid),   32'd0);
        @(posedge clk); #1;
        check("sh resp valid",   32'(resp_valid),   32'd1);
        check("sh resp err",     32'(resp_err),     32'd0);
        check("sh resp rdata",   resp_rdata,        32'h0);
        check("sh resp mem_we",  32'(mem_we),       32'd0);
        check("sh ram 1004",     32'(ram[17'h01004]), 32'h0000_00DD);
        check("sh ram 1005",     32'(ram[17'h01005]), 32'h0000_00CC);
        check("sh ram 1006",     32'(ram[17'h01006]), 32'h0000_0077);

        // Reset during SPLIT of SH 0x1024: only the low byte lands, no response.
        wait_ready();
        rc0 = resp_count;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h0000_1024; req_wdata = 32'h0000_1234;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst split we",    32'(mem_we),   32'd1);
        check("rst split addr",  mem_addr,      32'h0000_1025);
        rst_n = 1'b0;
        #1;
        check("rst async mem_we", 32'(mem_we),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst ready after",  32'(req_ready),         32'd1);
        check("rst no resp",      32'(resp_count - rc0),  32'd0);
        check("rst ram 1024",     32'(ram[17'h01024]),    32'h0000_0034);
        check("rst ram 1025",     32'(ram[17'h01025]),    32'h0000_0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
